// File: rtl/cam_capture_rgb111_pkg.sv
// Shared definitions for the RGB565 -> RGB111 camera capture stage:
// FSM state encoding, bit positions and default image geometry.
package cam_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    BYTE1      = 2'd1,
    BYTE2      = 2'd2
  } cap_state_e;

  localparam int RGB_R = 2;
  localparam int RGB_G = 1;
  localparam int RGB_B = 0;

  // Source bits: MSB of each colour field in the RGB565 byte pair
  localparam int SRC_R = 7;
  localparam int SRC_G = 2;
  localparam int SRC_B = 4;

  localparam int DEF_IMG_W = 160;
  localparam int DEF_IMG_H = 120;

  function automatic logic [2:0] rgb111(input logic r, input logic g, input logic b);
    logic [2:0] p;
    p        = '0;
    p[RGB_R] = r;
    p[RGB_G] = g;
    p[RGB_B] = b;
    return p;
  endfunction

endpackage

// File: rtl/cam_capture_rgb111_if.sv
// Camera-side inputs and frame-buffer write outputs of the capture stage.
// frame_cnt exists only when CAM_FRAME_CNT_EN is defined.
interface cam_capture_rgb111_if #(
  parameter int AW = 15,
  parameter int DW = 3
);
  logic          en;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;
  logic          frame_done;
`ifdef CAM_FRAME_CNT_EN
  logic [7:0]    frame_cnt;

  modport master (output en, vsync, href, px_data,
                  input  mem_px_addr, mem_px_data, px_wr, frame_done, frame_cnt);
  modport slave  (input  en, vsync, href, px_data,
                  output mem_px_addr, mem_px_data, px_wr, frame_done, frame_cnt);
`else
  modport master (output en, vsync, href, px_data,
                  input  mem_px_addr, mem_px_data, px_wr, frame_done);
  modport slave  (input  en, vsync, href, px_data,
                  output mem_px_addr, mem_px_data, px_wr, frame_done);
`endif
endinterface

// File: rtl/cam_capture_rgb111_sync_edge.sv
// Registers vsync once and flags its falling (frame start) and rising
// (frame end) edges as combinational single-cycle pulses.
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_vsync,
  output logic o_frame_start,
  output logic o_frame_end
);
  logic r_vsync_d;

  // Reset high so a camera already in blanking produces no spurious edge
  always_ff @(posedge clk) begin
    if (rst) r_vsync_d <= 1'b1;
    else     r_vsync_d <= i_vsync;
  end

  assign o_frame_start = r_vsync_d & ~i_vsync;
  assign o_frame_end   = ~r_vsync_d & i_vsync;

endmodule

// File: rtl/cam_capture_rgb111.sv
// Camera capture: packs RGB565 byte pairs into RGB111 frame-buffer writes.
// Optional macro CAM_FRAME_CNT_EN adds a count of fully written frames.
module cam_capture_rgb111
  import cam_pkg::*;
#(
  parameter int AW    = 15,
  parameter int DW    = 3,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                 clk,
  input  logic                 rst,
  cam_capture_rgb111_if.slave  bus
);
  localparam int          NPIX    = IMG_W * IMG_H;
  // One extra bit so the counter can sit at NPIX even when NPIX == 2**AW
  localparam logic [AW:0] PIX_MAX = (AW+1)'(NPIX);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  cap_state_e    r_state;
  logic [AW:0]   r_cnt;
  logic          r_r, r_g;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_wr;
  logic          r_done;

  logic w_fstart, w_fend, w_full, w_end_cap;
  logic w_unused_px;

  cam_sync_edge u_sync (
    .clk           (clk),
    .rst           (rst),
    .i_vsync       (bus.vsync),
    .o_frame_start (w_fstart),
    .o_frame_end   (w_fend)
  );

  assign w_full      = (r_cnt == PIX_MAX);
  assign w_end_cap   = w_fend && (r_state == BYTE1 || r_state == BYTE2);
  assign w_unused_px = ^{bus.px_data[6:5], bus.px_data[3], bus.px_data[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_FRAME;
      r_cnt   <= '0;
      r_r     <= 1'b0;
      r_g     <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        WAIT_FRAME: begin
          if (w_fstart && bus.en) begin
            r_cnt   <= '0;
            r_state <= BYTE1;
          end
        end
        BYTE1: begin
          if (w_fend) begin
            r_done  <= 1'b1;
            r_state <= WAIT_FRAME;
          end else if (bus.href) begin
            r_r     <= bus.px_data[SRC_R];
            r_g     <= bus.px_data[SRC_G];
            r_state <= BYTE2;
          end
        end
        BYTE2: begin
          // A lone first byte (href dropped or frame ended) is simply discarded
          if (w_fend) begin
            r_done  <= 1'b1;
            r_state <= WAIT_FRAME;
          end else begin
            if (bus.href && !w_full) begin
              r_data <= DW'(rgb111(r_r, r_g, bus.px_data[SRC_B]));
              r_addr <= r_cnt[AW-1:0];
              r_wr   <= 1'b1;
              r_cnt  <= r_cnt + CNT_ONE;
            end
            r_state <= BYTE1;
          end
        end
        default: r_state <= WAIT_FRAME;
      endcase
    end
  end

  assign bus.mem_px_addr = r_addr;
  assign bus.mem_px_data = r_data;
  assign bus.px_wr       = r_wr;
  assign bus.frame_done  = r_done;

`ifdef CAM_FRAME_CNT_EN
  logic [7:0] r_fcnt;

  always_ff @(posedge clk) begin
    if (rst)                      r_fcnt <= '0;
    else if (w_end_cap && w_full) r_fcnt <= r_fcnt + 8'd1;
  end

  assign bus.frame_cnt = r_fcnt;
`endif

endmodule

// File: tb/tb_cam_capture_rgb111.sv
// Scoreboard bench for cam_capture_rgb111: frame-level stimulus feeds a
// pixel-pairing reference model; a negedge monitor checks every write/done.
module tb_cam_capture_rgb111;
  localparam int AW    = 15;
  localparam int DW    = 3;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int NPIX  = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  cam_capture_rgb111_if #(.AW(AW), .DW(DW)) bus ();

  cam_capture_rgb111 #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int cyc; int fcnt; } done_t;

  wr_t        wq[$];
  done_t      dq[$];
  logic [7:0] bq[$];
  int         m_pix;
  int         m_fcnt;
  bit         m_cap;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp_v);
  endtask

  // RGB111 value of a byte pair: R = first[7], G = first[2], B = second[4]
  function automatic int pix_of(input int b1, input int b2);
    return ((b1 >> 7) & 1) * 4 + ((b1 >> 2) & 1) * 2 + ((b2 >> 4) & 1);
  endfunction

  // Values driven here are sampled at the next posedge; on return cyc is that sample cycle
  task automatic step(input logic v, input logic h, input logic [7:0] d);
    bus.vsync   = v;
    bus.href    = h;
    bus.px_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_begin(input logic en_v);
    bus.en = en_v;
    step(1'b0, 1'b0, 8'($urandom));
    m_cap = en_v;
    m_pix = 0;
    step(1'b0, 1'b0, 8'($urandom));
  endtask

  // One href run; complete byte pairs become pixels, a trailing odd byte is lost
  task automatic send_row(input int gap);
    for (int i = 0; i < bq.size(); i++) begin
      step(1'b0, 1'b1, bq[i]);
      if ((i % 2) == 1 && m_cap && m_pix < NPIX) begin
        wq.push_back('{cyc, m_pix, pix_of(int'(bq[i-1]), int'(bq[i]))});
        m_pix++;
      end
    end
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic rand_bytes(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
  endtask

  task automatic end_frame();
    step(1'b1, 1'b0, 8'($urandom));
    if (m_cap) begin
      if (m_pix == NPIX) m_fcnt = (m_fcnt + 1) % 256;
      dq.push_back('{cyc, m_fcnt});
    end
    m_cap = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(bus.mem_px_addr), 32'd0);
    check({tag, "_data"}, 32'(bus.mem_px_data), 32'd0);
    check({tag, "_wr"},   32'(bus.px_wr),       32'd0);
    check({tag, "_done"}, 32'(bus.frame_done),  32'd0);
`ifdef CAM_FRAME_CNT_EN
    check({tag, "_fcnt"}, 32'(bus.frame_cnt),   32'd0);
`endif
  endtask

  // Monitor: every write or done pulse, actual or expected, is compared
  always @(negedge clk) begin
    logic exp_wr, exp_done;
    exp_wr   = (wq.size() > 0) && (wq[0].cyc == cyc);
    exp_done = (dq.size() > 0) && (dq[0].cyc == cyc);
    if (bus.px_wr === 1'b1 || exp_wr) begin
      check("px_wr", 32'(bus.px_wr), 32'(exp_wr));
      if (exp_wr) begin
        if (bus.px_wr === 1'b1) begin
          check("mem_px_addr", 32'(bus.mem_px_addr), 32'(wq[0].addr));
          check("mem_px_data", 32'(bus.mem_px_data), 32'(wq[0].data));
        end
        void'(wq.pop_front());
      end
    end
    if (bus.frame_done === 1'b1 || exp_done) begin
      check("frame_done", 32'(bus.frame_done), 32'(exp_done));
      if (exp_done) begin
`ifdef CAM_FRAME_CNT_EN
        check("frame_cnt", 32'(bus.frame_cnt), 32'(dq[0].fcnt));
`endif
        void'(dq.pop_front());
      end
    end
  end

  initial begin
    bus.en      = 1'b0;
    bus.vsync   = 1'b1;
    bus.href    = 1'b0;
    bus.px_data = 8'h00;
    m_fcnt      = 0;
    m_cap       = 1'b0;
    m_pix       = 0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;

    // First pixel: 0x84,0x10 -> 3'b111 at address 0; frame ends in BYTE1
    frame_begin(1'b1);
    bq = '{8'h84, 8'h10};
    send_row(2);
    end_frame();

    // One continuous row of 0xF8,0x00 -> IMG_W writes of 3'b100
    frame_begin(1'b1);
    bq.delete();
    for (int i = 0; i < IMG_W; i++) begin
      bq.push_back(8'hF8);
      bq.push_back(8'h00);
    end
    send_row(2);
    end_frame();

    // Odd row of 3 bytes, then a 5-byte row left in BYTE2 when vsync rises
    frame_begin(1'b1);
    rand_bytes(3);
    send_row(1);
    rand_bytes(5);
    send_row(0);
    end_frame();

    // Capture disabled at frame start; enabling mid-frame changes nothing
    frame_begin(1'b0);
    for (int r = 0; r < 3; r++) begin
      if (r == 1) bus.en = 1'b1;
      rand_bytes(20);
      send_row(2);
    end
    end_frame();

    // Random row lengths and gaps with en toggling during the frame
    frame_begin(1'b1);
    for (int r = 0; r < 12; r++) begin
      bus.en = 1'($urandom);
      rand_bytes(int'($urandom_range(0, 41)));
      send_row(int'($urandom_range(1, 3)));
    end
    end_frame();

    // Full frame plus two surplus rows that must be dropped
    frame_begin(1'b1);
    for (int r = 0; r < IMG_H + 2; r++) begin
      rand_bytes(2 * IMG_W);
      send_row(int'($urandom_range(1, 2)));
    end
    end_frame();

    // Reset mid-frame with a half pixel pending: no write, no done
    frame_begin(1'b1);
    rand_bytes(7);
    send_row(0);
    rst       = 1'b1;
    bus.vsync = 1'b1;
    bus.href  = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_cap  = 1'b0;
    m_fcnt = 0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'($urandom));

    check("wr_queue_left",   32'(wq.size()), 32'd0);
    check("done_queue_left", 32'(dq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
